// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM: idle, data access in flight, instruction access in flight.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2
    } arb_state_t;

    // Default number of cycles an access may wait for mem_ready.
    localparam int TIMEOUT_DEF = 64;

    // Wait-timer width; at least one bit even for the smallest legal TIMEOUT.
    function automatic int timer_w(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles an access has been waiting for mem_ready and flags the last
// allowed cycle so the arbiter can abort instead of hanging.
module mem_wait_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int              W    = timer_w(TIMEOUT);
    localparam logic [W-1:0]    LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    // Cycle counter; saturates at LAST so it never wraps during an abort cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != LAST))
            r_cnt <= r_cnt + W'(1);
    end

    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (IF) and load/store (MEM).
// Data is served before instruction; a global stall holds the pipeline until
// every active requester has been served, and read data is held in registers
// so both stages see their results in the release cycle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              err
);

    arb_state_t        r_state, w_next;
    logic              r_if_done, r_dm_done;
    logic              r_mem_req, r_mem_we, r_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_dm_rdata;

    logic w_dm_act, w_dm_pend, w_if_pend;
    logic w_issue_d, w_issue_i, w_fin, w_ok, w_abort;
    logic w_in_acc, w_expired;

    assign w_dm_act  = dm_read | dm_write;
    assign w_dm_pend = w_dm_act & ~r_dm_done;
    assign w_if_pend = if_req & ~r_if_done;
    assign w_in_acc  = (r_state != IDLE);

    // Pipeline holds while any active requester is still unserved.
    assign stall = w_if_pend | w_dm_pend;

    // Timer restarts in IDLE and whenever the memory answers.
    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (~w_in_acc | mem_ready),
        .i_en      (w_in_acc),
        .o_expired (w_expired)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state: data has priority; an access ends on ready or on timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_dm_pend)      w_next = D_ACC;
                else if (w_if_pend) w_next = I_ACC;
            end
            D_ACC, I_ACC: begin
                if (mem_ready || w_expired) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // FSM decode: issue strobes in IDLE, completion/abort strobes in an access.
    always_comb begin
        w_issue_d = 1'b0;
        w_issue_i = 1'b0;
        w_fin     = 1'b0;
        w_ok      = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            IDLE: begin
                w_issue_d = w_dm_pend;
                w_issue_i = ~w_dm_pend & w_if_pend;
            end
            D_ACC, I_ACC: begin
                w_ok    = mem_ready;
                w_abort = ~mem_ready & w_expired;
                w_fin   = mem_ready | w_expired;
            end
            default: ;
        endcase
    end

    // Memory request registers and held read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_issue_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= dm_write;   // read+write together is taken as a store
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
            end else if (w_issue_i) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= if_addr;
            end else if (w_fin) begin
                r_mem_req <= 1'b0;
            end
            // Latched we, not live dm_read, decides: the request may have dropped.
            if (w_ok && (r_state == D_ACC) && !r_mem_we)
                r_dm_rdata <= mem_rdata;
            if (w_ok && (r_state == I_ACC))
                r_if_rdata <= mem_rdata;
            if (w_abort)
                r_err <= 1'b1;
        end
    end

    // Done flags: set when an access ends, cleared on any edge where stall is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dm_done <= 1'b0;
            r_if_done <= 1'b0;
        end else begin
            if (w_fin && (r_state == D_ACC)) r_dm_done <= 1'b1;
            else if (!stall)                 r_dm_done <= 1'b0;
            if (w_fin && (r_state == I_ACC)) r_if_done <= 1'b1;
            else if (!stall)                 r_if_done <= 1'b0;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized pipeline
// steps checked against a transaction-level model (access order, stall length,
// held read data, sticky error).
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0, dm_read = 1'b0, dm_write = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          mem_req, mem_we, stall, err;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory contents; unwritten locations read as an address-derived pattern.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    acc_t act_q[$];
    acc_t exp_q[$];
    int   lat_q[$];

    // Memory responder: each access waits the latency queued for it.
    int cur_lat = 0;
    int wcnt = 0;
    bit busy = 0;
    always @(negedge clk) begin
        if (!rst_n || !mem_req) begin
            mem_ready = 1'b0;
            busy = 0;
        end else begin
            if (!busy) begin
                busy = 1;
                wcnt = 0;
                cur_lat = 0;
                if (lat_q.size() > 0) cur_lat = lat_q.pop_front();
            end
            if (wcnt >= cur_lat) begin
                mem_ready = 1'b1;
                mem_rdata = rd(mem_addr);
                if (mem_we) mem[mem_addr] = mem_wdata;
                act_q.push_back('{mem_we, mem_addr, mem_wdata});
                busy = 0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0BAD0;
                wcnt++;
            end
        end
    end

    // Model state: held read data and sticky error as the pipeline should see them.
    logic [31:0] exp_if = '0;
    logic [31:0] exp_dm = '0;
    logic        exp_err = 1'b0;

    // One pipeline step: present requests, hold until stall drops, check results.
    task automatic step(input bit f, input bit ld, input bit st,
                        input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] wd, input int ilat, input int dlat);
        int  exp_st = 0, exp_rq = 0, n_st = 0, n_rq = 0, nmin;
        bit  dact, d_ok, i_ok;
        dact = ld | st;
        d_ok = 0;
        if (dact) begin
            d_ok = (dlat < TO);
            exp_st += 1 + (d_ok ? dlat + 1 : TO);
            exp_rq += d_ok ? dlat + 1 : TO;
            lat_q.push_back(dlat);
            if (!d_ok) exp_err = 1'b1;
            else begin
                exp_q.push_back('{st, da, wd});
                if (!st) exp_dm = rd(da);
            end
        end
        if (f) begin
            i_ok = (ilat < TO);
            exp_st += 1 + (i_ok ? ilat + 1 : TO);
            exp_rq += i_ok ? ilat + 1 : TO;
            lat_q.push_back(ilat);
            if (!i_ok) exp_err = 1'b1;
            else begin
                exp_q.push_back('{1'b0, ia, 32'h0});
                exp_if = (st && d_ok && ia == da) ? wd : rd(ia);
            end
        end
        if_req = f; if_addr = ia;
        dm_read = ld; dm_write = st; dm_addr = da; dm_wdata = wd;
        @(negedge clk);
        chk("req_c0", 32'(mem_req), 32'h0);
        while (stall && n_st < 200) begin
            n_st++;
            if (mem_req) n_rq++;
            @(negedge clk);
        end
        if (mem_req) n_rq++;
        chk("stall_cyc", 32'(n_st), 32'(exp_st));
        chk("req_cyc", 32'(n_rq), 32'(exp_rq));
        chk("if_rdata", if_rdata, exp_if);
        chk("dm_rdata", dm_rdata, exp_dm);
        chk("err", 32'(err), 32'(exp_err));
        chk("n_acc", 32'(act_q.size()), 32'(exp_q.size()));
        nmin = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            chk("acc_we", 32'(act_q[i].we), 32'(exp_q[i].we));
            chk("acc_addr", act_q[i].addr, exp_q[i].addr);
            if (exp_q[i].we) chk("acc_wdata", act_q[i].wdata, exp_q[i].wdata);
        end
        act_q.delete(); exp_q.delete(); lat_q.delete();
        @(posedge clk); #1;
    endtask

    // Drop all requests for n cycles; nothing may be issued meanwhile.
    task automatic idle(input int n);
        if_req = 0; dm_read = 0; dm_write = 0;
        repeat (n) begin
            @(negedge clk);
            chk("idle_stall", 32'(stall), 32'h0);
            chk("idle_req", 32'(mem_req), 32'h0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit          f, ld, st;
        int          op;
        logic [31:0] ia, da, wd;
        int          il, dl, r;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_if", if_rdata, 32'h0);
        chk("rst_dm", dm_rdata, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        mem[32'h40]  = 32'h8C010004;
        mem[32'h44]  = 32'h00221820;
        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h48]  = 32'h11112222;
        mem[32'h4C]  = 32'h33334444;

        step(1, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0);
        chk("fetch_val", if_rdata, 32'h8C010004);
        step(1, 1, 0, 32'h44, 32'h100, 32'h0, 2, 2);
        chk("load_val", dm_rdata, 32'hDEADBEEF);
        chk("fetch2_val", if_rdata, 32'h00221820);
        step(1, 0, 1, 32'h50, 32'h200, 32'h12345678, 0, 0);
        chk("store_hold", dm_rdata, 32'hDEADBEEF);
        chk("store_mem", mem[32'h200], 32'h12345678);
        step(1, 0, 0, 32'h48, 32'h0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h4C, 32'h0, 32'h0, 0, 0);
        idle(2);

        // Memory never answers: fetch then load both abort; err stays set.
        step(1, 0, 0, 32'h60, 32'h0, 32'h0, 100, 0);
        step(1, 0, 0, 32'h64, 32'h0, 32'h0, 1, 0);
        step(0, 1, 0, 32'h0, 32'h104, 32'h0, 0, 9);
        step(0, 1, 0, 32'h0, 32'h100, 32'h0, 0, 0);

        // Asynchronous reset in the middle of a data access.
        dm_read = 1; dm_addr = 32'h108; lat_q.push_back(100);
        repeat (3) @(negedge clk);
        chk("pre_rst_req", 32'(mem_req), 32'h1);
        #2;
        if_req = 0; dm_read = 0; dm_write = 0; rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'h0);
        chk("arst_stall", 32'(stall), 32'h0);
        chk("arst_if", if_rdata, 32'h0);
        chk("arst_dm", dm_rdata, 32'h0);
        chk("arst_err", 32'(err), 32'h0);
        chk("arst_addr", mem_addr, 32'h0);
        exp_if = '0; exp_dm = '0; exp_err = 1'b0;
        lat_q.delete(); act_q.delete(); exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 250; k++) begin
            f  = ($urandom_range(0, 99) < 75);
            op = $urandom_range(0, 3);
            ld = (op == 1) || (op == 3);
            st = (op >= 2);
            ia = 32'h300 + 32'($urandom_range(0, 15)) * 4;
            da = 32'h300 + 32'($urandom_range(0, 15)) * 4;
            wd = $urandom;
            r  = $urandom_range(0, 19);
            il = (r < 17) ? r % 4 : 4 + r % 3;
            r  = $urandom_range(0, 19);
            dl = (r < 17) ? r % 4 : 4 + r % 3;
            step(f, ld, st, ia, da, wd, il, dl);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
